// File: rtl/mult_div_unit.sv
// mult_div_unit: 32-bit iterative multiply/divide unit with HI/LO result registers.
//
// Multiply uses one radix-2 shift-add step per cycle. Divide uses one restoring
// shift-subtract step per cycle. Both work on operand magnitudes, and a final
// cycle applies the result signs. Every operation takes the same time: Start is
// sampled at edge N, and Done is high in the cycle after edge N+33.
//
// Optional feature: define MDU_DIV_EN to build the divide datapath. When it is
// undefined, DIV/DIVU are accepted as one-cycle no-ops that leave HI/LO unchanged.
//
// Ports:
//   clk         clock; all state changes on its rising edge
//   Reset       synchronous active-high reset
//   Start       request an operation; sampled only when Busy=0
//   Op          00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   Operand_A   multiplicand / dividend
//   Operand_B   multiplier / divisor
//   Write_data  value written by Mthi/Mtlo
//   Mthi, Mtlo  write Write_data into HI / LO while idle
//   HI_out      HI register (product high word / remainder)
//   LO_out      LO register (product low word / quotient)
//   Busy        operation in progress
//   Done        one-cycle pulse when HI/LO take a finished result
module mult_div_unit (
   input  logic        clk,
   input  logic        Reset,
   input  logic        Start,
   input  logic [1:0]  Op,
   input  logic [31:0] Operand_A,
   input  logic [31:0] Operand_B,
   input  logic [31:0] Write_data,
   input  logic        Mthi,
   input  logic        Mtlo,
   output logic [31:0] HI_out,
   output logic [31:0] LO_out,
   output logic        Busy,
   output logic        Done
);

   typedef enum logic [1:0] {StIdle, StRun, StFix} state_e;

   state_e      state_q, state_d;
   logic [4:0]  cnt_q;
   logic        is_div_q;
   logic        neg_lo_q;        // negate the product, or the quotient for a divide
   logic [31:0] acc_hi_q, acc_lo_q, opnd_q;
   logic [31:0] hi_q, lo_q;
   logic        done_q;

   // Operand magnitudes. Unsigned ops pass the raw values through.
   logic        a_neg, b_neg;
   logic [31:0] a_abs, b_abs;
   assign a_neg = ~Op[0] & Operand_A[31];
   assign b_neg = ~Op[0] & Operand_B[31];
   assign a_abs = a_neg ? (32'd0 - Operand_A) : Operand_A;
   assign b_abs = b_neg ? (32'd0 - Operand_B) : Operand_B;

   // Multiply step: {acc_hi, acc_lo} holds the partial product and the remaining
   // multiplier bits. Add the multiplicand when the multiplier LSB is set, then shift right.
   logic [32:0] mul_sum;
   logic [63:0] prod_abs, prod_fix;
   assign mul_sum  = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opnd_q} : 33'd0);
   assign prod_abs = {acc_hi_q, acc_lo_q};
   assign prod_fix = neg_lo_q ? (64'd0 - prod_abs) : prod_abs;

`ifdef MDU_DIV_EN
   // Restoring divide: acc_hi is the partial remainder. acc_lo shifts dividend bits
   // out and quotient bits in. A zero divisor always "fits", which yields an
   // all-ones quotient and leaves the dividend as the remainder.
   logic        neg_hi_q;
   logic [32:0] div_shift, div_diff;
   logic        div_fits;
   logic [31:0] quo_fix, rem_fix;
   assign div_shift = {acc_hi_q, acc_lo_q[31]};
   assign div_diff  = div_shift - {1'b0, opnd_q};
   assign div_fits  = ~div_diff[32];
   assign quo_fix   = neg_lo_q ? (32'd0 - acc_lo_q) : acc_lo_q;
   assign rem_fix   = neg_hi_q ? (32'd0 - acc_hi_q) : acc_hi_q;
`endif

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle: begin
            if (Start) begin
`ifdef MDU_DIV_EN
               state_d = StRun;
`else
               state_d = Op[1] ? StFix : StRun;
`endif
            end
         end
         StRun:   if (cnt_q == 5'd31) state_d = StFix;
         StFix:   state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (Reset) state_q <= StIdle;
      else       state_q <= state_d;
   end

   always_ff @(posedge clk) begin
      if (Reset) begin
         cnt_q    <= 5'd0;
         is_div_q <= 1'b0;
         neg_lo_q <= 1'b0;
         acc_hi_q <= 32'd0;
         acc_lo_q <= 32'd0;
         opnd_q   <= 32'd0;
         hi_q     <= 32'd0;
         lo_q     <= 32'd0;
         done_q   <= 1'b0;
`ifdef MDU_DIV_EN
         neg_hi_q <= 1'b0;
`endif
      end else begin
         done_q <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (Start) begin
                  is_div_q <= Op[1];
                  cnt_q    <= 5'd0;
                  acc_hi_q <= 32'd0;
`ifdef MDU_DIV_EN
                  if (Op[1]) begin
                     acc_lo_q <= a_abs;
                     opnd_q   <= b_abs;
                     // A zero divisor keeps the all-ones quotient unsigned.
                     neg_lo_q <= (a_neg ^ b_neg) && (Operand_B != 32'd0);
                     neg_hi_q <= a_neg;
                  end else
`endif
                  begin
                     acc_lo_q <= b_abs;
                     opnd_q   <= a_abs;
                     neg_lo_q <= a_neg ^ b_neg;
                  end
               end else begin
                  if (Mthi) hi_q <= Write_data;
                  if (Mtlo) lo_q <= Write_data;
               end
            end
            StRun: begin
               cnt_q <= cnt_q + 5'd1;
`ifdef MDU_DIV_EN
               if (is_div_q) begin
                  acc_hi_q <= div_fits ? div_diff[31:0] : div_shift[31:0];
                  acc_lo_q <= {acc_lo_q[30:0], div_fits};
               end else
`endif
               begin
                  acc_hi_q <= mul_sum[32:1];
                  acc_lo_q <= {mul_sum[0], acc_lo_q[31:1]};
               end
            end
            StFix: begin
               done_q <= 1'b1;
`ifdef MDU_DIV_EN
               if (is_div_q) begin
                  hi_q <= rem_fix;
                  lo_q <= quo_fix;
               end else
`else
               if (!is_div_q)
`endif
               begin
                  hi_q <= prod_fix[63:32];
                  lo_q <= prod_fix[31:0];
               end
            end
            default: ;
         endcase
      end
   end

   assign HI_out = hi_q;
   assign LO_out = lo_q;
   assign Busy   = (state_q != StIdle);
   assign Done   = done_q;

endmodule
